// File: rtl/execute_multiply_divide_unit_if.sv
// Execute-stage HI/LO multiply/divide unit: operand, control and result bundle.
// The pipeline side is the master; the multiply/divide unit is the slave.
interface execute_multiply_divide_unit_if #(
    parameter int WIDTH = 32
);
    logic [5:0]       ALU_function_execute;
    logic             HI_register_write_execute;
    logic             LO_register_write_execute;
    logic             using_HI_LO_execute;
    logic [WIDTH-1:0] src_A_execute;
    logic [WIDTH-1:0] src_B_execute;
    logic [WIDTH-1:0] HI_value;
    logic [WIDTH-1:0] LO_value;
    logic             busy;
    logic             stall_request;
    logic             done;

    modport master (
        output ALU_function_execute,
        output HI_register_write_execute,
        output LO_register_write_execute,
        output using_HI_LO_execute,
        output src_A_execute,
        output src_B_execute,
        input  HI_value,
        input  LO_value,
        input  busy,
        input  stall_request,
        input  done
    );

    modport slave (
        input  ALU_function_execute,
        input  HI_register_write_execute,
        input  LO_register_write_execute,
        input  using_HI_LO_execute,
        input  src_A_execute,
        input  src_B_execute,
        output HI_value,
        output LO_value,
        output busy,
        output stall_request,
        output done
    );
endinterface

// File: rtl/execute_multiply_divide_unit.sv
// Execute-stage HI/LO multiply/divide unit: iterative shift-add multiply,
// restoring divide, MTHI/MTLO. Optional macro: MDU_FAST_MULTIPLY_EN.
module execute_multiply_divide_unit #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic reset,
    execute_multiply_divide_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     dvs;
    logic                 neg_q;
    logic                 neg_r;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 done_q;

    logic [5:0]           funct;
    logic                 hw;
    logic                 lw;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 idle;
    logic                 is_mult;
    logic                 is_div;
    logic                 mult_go;
    logic                 div_go;
    logic                 mthi_go;
    logic                 mtlo_go;
    logic                 sgn;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 last;

    logic [WIDTH:0]       add_hi;
    logic [2*WIDTH-1:0]   prod_step;
    logic [2*WIDTH-1:0]   mul_res;
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       diff;
    logic                 ge;
    logic [WIDTH-1:0]     rem_step;
    logic [WIDTH-1:0]     quo_step;
    logic [WIDTH-1:0]     q_res;
    logic [WIDTH-1:0]     r_res;
`ifdef MDU_FAST_MULTIPLY_EN
    logic [2*WIDTH-1:0]   fast_prod;
    logic [2*WIDTH-1:0]   fast_res;
`endif

    assign funct = bus.ALU_function_execute;
    assign hw    = bus.HI_register_write_execute;
    assign lw    = bus.LO_register_write_execute;
    assign a     = bus.src_A_execute;
    assign b     = bus.src_B_execute;

    // Issue decode, operand sign handling and one iteration of each datapath
    always_comb begin
        idle    = (state_q == IDLE);
        is_mult = (funct == 6'h18) || (funct == 6'h19);
        is_div  = (funct == 6'h1A) || (funct == 6'h1B);
        mult_go = idle && hw && lw && is_mult;
        div_go  = idle && hw && lw && is_div && (b != '0);
        mthi_go = idle && hw && !lw && (funct == 6'h11);
        mtlo_go = idle && !hw && lw && (funct == 6'h13);
        // Even function codes (MULT, DIV) are the signed variants
        sgn     = ~funct[0];
        a_neg   = sgn & a[WIDTH-1];
        b_neg   = sgn & b[WIDTH-1];
        a_mag   = a_neg ? -a : a;
        b_mag   = b_neg ? -b : b;
        last    = (count == CW'(WIDTH-1));

        add_hi    = prod[0] ? ({1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand})
                            : {1'b0, prod[2*WIDTH-1:WIDTH]};
        prod_step = {add_hi, prod[WIDTH-1:1]};
        mul_res   = neg_q ? -prod_step : prod_step;

        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {1'b0, dvs};
        ge       = ~diff[WIDTH];
        rem_step = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_step = {quo[WIDTH-2:0], ge};
        q_res    = neg_q ? -quo_step : quo_step;
        r_res    = neg_r ? -rem_step : rem_step;
`ifdef MDU_FAST_MULTIPLY_EN
        fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
        fast_res  = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
`endif
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: leave IDLE on an accepted iterative op, return after WIDTH steps
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
`ifndef MDU_FAST_MULTIPLY_EN
                if (mult_go) state_d = MUL;
`endif
                if (div_go)  state_d = DIV;
            end
            MUL:     if (last) state_d = IDLE;
            DIV:     if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath, HI/LO and done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            prod   <= '0;
            mcand  <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    count <= '0;
                    if (mthi_go) hi_q <= a;
                    if (mtlo_go) lo_q <= a;
`ifdef MDU_FAST_MULTIPLY_EN
                    if (mult_go) begin
                        hi_q   <= fast_res[2*WIDTH-1:WIDTH];
                        lo_q   <= fast_res[WIDTH-1:0];
                        done_q <= 1'b1;
                    end
`else
                    if (mult_go) begin
                        prod  <= {{WIDTH{1'b0}}, b_mag};
                        mcand <= a_mag;
                        neg_q <= a_neg ^ b_neg;
                    end
`endif
                    if (div_go) begin
                        rem   <= '0;
                        quo   <= a_mag;
                        dvs   <= b_mag;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                    end
                end
                MUL: begin
                    prod  <= prod_step;
                    count <= count + CW'(1);
                    if (last) begin
                        hi_q   <= mul_res[2*WIDTH-1:WIDTH];
                        lo_q   <= mul_res[WIDTH-1:0];
                        done_q <= 1'b1;
                    end
                end
                DIV: begin
                    rem   <= rem_step;
                    quo   <= quo_step;
                    count <= count + CW'(1);
                    if (last) begin
                        hi_q   <= r_res;
                        lo_q   <= q_res;
                        done_q <= 1'b1;
                    end
                end
                default: count <= '0;
            endcase
        end
    end

    assign bus.HI_value      = hi_q;
    assign bus.LO_value      = lo_q;
    assign bus.done          = done_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.stall_request = bus.busy & (hw | lw | bus.using_HI_LO_execute);
endmodule

// File: tb/tb_execute_multiply_divide_unit.sv
// Bench for execute_multiply_divide_unit: arithmetic reference model,
// per-cycle output compare, directed literal pins and random instructions.
module tb_execute_multiply_divide_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;

    execute_multiply_divide_unit_if #(.WIDTH(W)) bus ();

    execute_multiply_divide_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    int          m_rem = 0;
    logic        m_done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] calc(input logic [5:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0;
        case (f)
            6'h18: r = sa * sb;
            6'h19: r = {32'b0, a} * {32'b0, b};
            6'h1A: r = {32'(sa % sb), 32'(sa / sb)};
            6'h1B: r = {a % b, a / b};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Reference model: state advances on every clock edge or reset assertion
    initial begin
        logic [5:0]  f;
        logic        hw;
        logic        lw;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] r;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_hi = '0; m_lo = '0; m_rem = 0; m_done = 1'b0;
            end else begin
                m_done = 1'b0;
                f  = bus.ALU_function_execute;
                hw = bus.HI_register_write_execute;
                lw = bus.LO_register_write_execute;
                a  = bus.src_A_execute;
                b  = bus.src_B_execute;
                if (m_rem > 0) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                    end
                end else if (hw && lw && (f == 6'h18 || f == 6'h19)) begin
                    r = calc(f, a, b);
`ifdef MDU_FAST_MULTIPLY_EN
                    {m_hi, m_lo} = r;
                    m_done = 1'b1;
`else
                    {p_hi, p_lo} = r;
                    m_rem = W;
`endif
                end else if (hw && lw && (f == 6'h1A || f == 6'h1B) && b != 0) begin
                    {p_hi, p_lo} = calc(f, a, b);
                    m_rem = W;
                end else if (hw && !lw && f == 6'h11) begin
                    m_hi = a;
                end else if (!hw && lw && f == 6'h13) begin
                    m_lo = a;
                end
            end
        end
    end

    // Every-cycle compare against the model
    always @(negedge clk) begin
        chk("hi", bus.HI_value, m_hi);
        chk("lo", bus.LO_value, m_lo);
        chk("busy", bus.busy, m_rem > 0);
        chk("done", bus.done, m_done);
        chk("stall", bus.stall_request,
            (m_rem > 0) && (bus.HI_register_write_execute ||
                            bus.LO_register_write_execute ||
                            bus.using_HI_LO_execute));
    end

    task automatic drive(input logic [5:0] f, input logic hw, input logic lw,
                         input logic use_hl, input logic [31:0] a, input logic [31:0] b);
        bus.ALU_function_execute      = f;
        bus.HI_register_write_execute = hw;
        bus.LO_register_write_execute = lw;
        bus.using_HI_LO_execute       = use_hl;
        bus.src_A_execute             = a;
        bus.src_B_execute             = b;
    endtask

    // Present one instruction, hold it while the unit is busy, then retire it
    task automatic present(input logic [5:0] f, input logic hw, input logic lw,
                           input logic use_hl, input logic [31:0] a, input logic [31:0] b);
        int n;
        drive(f, hw, lw, use_hl, a, b);
        n = 0;
        while (m_rem != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("present_timeout", 1, 0);
        @(posedge clk); #1;
        drive(6'h00, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_rem != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("idle_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    logic [5:0] fl [9] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13, 6'h10, 6'h12, 6'h00};
    logic [31:0] sp [5] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h1, 32'h7FFFFFFF};

    function automatic logic [31:0] rnd_op();
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int cnt;
        logic [5:0] f;
        logic hw;
        logic lw;
        drive(6'h00, 1'b0, 1'b0, 1'b0, '0, '0);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_hi", bus.HI_value, 32'h0);
        chk("rst_lo", bus.LO_value, 32'h0);
        chk("rst_busy", bus.busy, 1'b0);

        // Reset in the middle of an iterative multiply
        present(6'h18, 1'b1, 1'b1, 1'b0, 32'd3, 32'd5);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_hi", bus.HI_value, 32'h0);
        chk("midrst_lo", bus.LO_value, 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        present(6'h18, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h2);
        wait_idle();
        chk("mult_hi", bus.HI_value, 32'hFFFFFFFF);
        chk("mult_lo", bus.LO_value, 32'hFFFFFFFE);
        chk("model_mult", {m_hi, m_lo}, 64'hFFFFFFFF_FFFFFFFE);

        present(6'h19, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h2);
        wait_idle();
        chk("multu_hi", bus.HI_value, 32'h1);
        chk("multu_lo", bus.LO_value, 32'hFFFFFFFE);

        present(6'h1A, 1'b1, 1'b1, 1'b0, 32'hFFFFFFF9, 32'h2);
        wait_idle();
        chk("div_lo", bus.LO_value, 32'hFFFFFFFD);
        chk("div_hi", bus.HI_value, 32'hFFFFFFFF);

        present(6'h1B, 1'b1, 1'b1, 1'b0, 32'd100, 32'd7);
        wait_idle();
        chk("divu_lo", bus.LO_value, 32'd14);
        chk("divu_hi", bus.HI_value, 32'd2);

        present(6'h1A, 1'b1, 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();
        chk("divovf_lo", bus.LO_value, 32'h80000000);
        chk("divovf_hi", bus.HI_value, 32'h0);
        chk("model_divovf", {m_hi, m_lo}, 64'h00000000_80000000);

        // MFHI right behind a DIVU stalls for the whole divide
        present(6'h1B, 1'b1, 1'b1, 1'b0, 32'd100, 32'd7);
        drive(6'h10, 1'b0, 1'b0, 1'b1, '0, '0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.stall_request) break;
            cnt++;
        end
        chk("hazard_stall_cycles", cnt, 32);
        chk("hazard_hi", bus.HI_value, 32'd2);
        @(posedge clk); #1;
        drive(6'h00, 1'b0, 1'b0, 1'b0, '0, '0);

        // MTLO held behind a busy multiply
        present(6'h19, 1'b1, 1'b1, 1'b0, 32'd3, 32'd5);
        present(6'h13, 1'b0, 1'b1, 1'b0, 32'h1234, 32'h0);
        chk("mtlo_lo", bus.LO_value, 32'h1234);
        chk("mtlo_hi", bus.HI_value, 32'h0);

        // Divide by zero leaves HI/LO alone
        present(6'h11, 1'b1, 1'b0, 1'b0, 32'hAAAA, 32'h0);
        present(6'h13, 1'b0, 1'b1, 1'b0, 32'h5555, 32'h0);
        present(6'h1A, 1'b1, 1'b1, 1'b0, 32'h1234, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("dz_busy", bus.busy, 1'b0);
        chk("dz_hi", bus.HI_value, 32'hAAAA);
        chk("dz_lo", bus.LO_value, 32'h5555);

        present(6'h19, 1'b1, 1'b1, 1'b0, 32'd3, 32'd5);
`ifdef MDU_FAST_MULTIPLY_EN
        chk("fast_busy", bus.busy, 1'b0);
        chk("fast_lo_now", bus.LO_value, 32'd15);
`endif
        wait_idle();
        chk("m35_lo", bus.LO_value, 32'd15);
        chk("m35_hi", bus.HI_value, 32'd0);

        // Random instruction stream, back-to-back or with gaps
        for (int i = 0; i < 200; i++) begin
            f = fl[$urandom_range(0, 8)];
            hw = $urandom_range(0, 1);
            lw = $urandom_range(0, 1);
            if (f[4:3] == 2'b11 && $urandom_range(0, 9) != 0) begin
                hw = 1'b1; lw = 1'b1;
            end
            present(f, hw, lw, $urandom_range(0, 4) == 0, rnd_op(), rnd_op());
            if ($urandom_range(0, 2) == 0) wait_idle();
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/execute_multiply_divide_unit.md
Name: execute_multiply_divide_unit

Overview:
- Execute-stage HI/LO multiply/divide unit.
- Consumes the control and operand outputs of the decode/execute pipeline register: ALU function code, HI/LO write enables, HI/LO usage flag, src A/B.
- Runs MULT/MULTU/DIV/DIVU iteratively and handles MTHI/MTLO.
- Owns the architectural HI and LO registers and requests pipeline stalls while an operation is in flight.

Parameters:
WIDTH, 32, operand/HI/LO width; iterative latency equals WIDTH cycles

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
ALU_function_execute  input  6  MIPS funct: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x11 MTHI, 0x13 MTLO
HI_register_write_execute  input  1  instruction writes HI
LO_register_write_execute  input  1  instruction writes LO
using_HI_LO_execute  input  1  instruction reads HI/LO (MFHI/MFLO)
src_A_execute  input  WIDTH  rs operand (dividend/multiplicand/MTxx data)
src_B_execute  input  WIDTH  rt operand (divisor/multiplier)
HI_value  output  WIDTH  architectural HI
LO_value  output  WIDTH  architectural LO
busy  output  1  iterative operation in flight
stall_request  output  1  hold the decode/execute register and upstream stages
done  output  1  one-cycle pulse on the edge HI/LO are written by a mult/div

Behaviour:
- Reset (async, any time including mid-operation): HI_value=0, LO_value=0, state IDLE, counter=0, busy=0, done=0. The in-flight operation is discarded.
- Issue: only in IDLE.
  - mult/div requires HI_write & LO_write & funct in 0x18–0x1B.
  - MTHI requires HI_write only, funct 0x11: HI_value<=src_A at the next edge, no busy.
  - MTLO requires LO_write only, funct 0x13: LO_value<=src_A at the next edge, no busy.
  - Any other combination: no action.
- stall_request is combinational: busy & (HI_write | LO_write | using_HI_LO). Inputs are ignored while busy; the stalled instruction is re-presented and issues in the first IDLE cycle.
- States:
  - IDLE -> MUL on a mult issue; IDLE -> DIV on a div issue with src_B != 0.
  - MUL/DIV: one iteration per cycle, counter 0..WIDTH-1. On the edge where counter==WIDTH-1: write HI/LO, pulse done, return to IDLE.
  - busy=1 exactly in MUL/DIV, i.e. WIDTH cycles after the issue edge.
  - The instruction following an MFHI-dependent op stalls for WIDTH cycles, then reads the new values.
- Multiply: shift-add on magnitudes. The signed variant negates the 2*WIDTH product if operand signs differ. {HI,LO} = product.
- Divide: restoring on magnitudes. LO=quotient, HI=remainder. Signed variant: quotient negated if signs differ; remainder takes the dividend's sign.
  - 0x80000000 / -1 (DIV): LO=0x80000000, HI=0.
- Divide by zero (src_B==0, DIV/DIVU): no iteration, busy stays 0, HI/LO unchanged, done not pulsed.
- MTHI/MTLO/mult/div never issue on the same cycle as each other (single instruction per cycle); no arbitration is needed.
- done and busy are registered outputs.

Optional Feature:
- MDU_FAST_MULTIPLY_EN defined: MULT/MULTU complete combinationally. HI/LO are written on the issue edge with done pulsed on that edge; busy is never raised for multiplies. Divide is unchanged.
- MDU_FAST_MULTIPLY_EN undefined: multiplies take WIDTH cycles as above.

Test Plan:
- Reset mid-op: MULT issued, reset asserted 5 cycles in -> HI_value=0, LO_value=0, busy=0 immediately, no done pulse.
- MULT 0xFFFFFFFF x 0x00000002 -> after 32 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE, done for 1 cycle. MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Hazard: DIVU issued, MFHI (using_HI_LO=1) presented the next cycle -> stall_request=1 for 32 cycles, drops on the cycle after done, HI_value then valid. MTLO 0x1234 presented while busy -> stalled, LO=0x1234 written one cycle after busy falls.
- Divide by zero: DIV src_B=0 with HI=0xAAAA, LO=0x5555 -> busy stays 0, HI/LO unchanged, no done.
- With MDU_FAST_MULTIPLY_EN: MULTU 3x5 -> LO=15, HI=0 on the issue edge, busy never asserted, stall_request=0.
